iterative_shifter: RTL

- Parametrised multi-cycle shift/rotate unit. It replaces the fixed 8-bit free-running shifting register.
- Adds an explicit Start/Busy/Done handshake, a configurable data width and a configurable number of bit-steps per clock.
- Adds carry-out and arithmetic-overflow flags.
- Sits between the switch/operand front end and the display/result register in the lab datapath.

---
 rtl/iterative_shifter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit with a Start/Busy/Done handshake.
// Up to STEP single-bit steps are applied per clock until the latched amount is used up.
module iterative_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4,
  parameter int STEP  = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Din,
  input  logic [AMT_W-1:0] Num,
  input  logic             Drc,
  input  logic [1:0]       Mode,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Dout,
  output logic             Cout,
  output logic             Ovf
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [AMT_W-1:0] rem_r, rem_s;
  logic             drc_r, drc_s;
  logic [1:0]       mode_r, mode_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] dout_r, dout_s;
  logic             cout_r, cout_s;
  logic             ovf_r, ovf_s;

  logic [WIDTH-1:0] walk_s;
  logic             walk_c_s;
  logic             walk_o_s;
  logic [AMT_W-1:0] rem_dec_s;

  // One single-bit step; result is {bit leaving the register, new state}.
  function automatic logic [WIDTH:0] step_once(input logic [WIDTH-1:0] s,
                                               input logic right,
                                               input logic [1:0] mode);
    logic           fill;
    logic [WIDTH:0] res;
    if (!right) begin
      case (mode)
        2'b10:   fill = s[WIDTH-1];
        2'b11:   fill = ~s[WIDTH-1];
        default: fill = 1'b0;
      endcase
      res = {s[WIDTH-1], s[WIDTH-2:0], fill};
    end else begin
      case (mode)
        2'b01:   fill = s[WIDTH-1];
        2'b10:   fill = s[0];
        2'b11:   fill = ~s[0];
        default: fill = 1'b0;
      endcase
      res = {s[0], fill, s[WIDTH-1:1]};
    end
    return res;
  endfunction

  // Apply min(STEP, rem) steps to the working register in one clock.
  always_comb begin : walk
    logic [WIDTH:0] stp;
    stp      = '0;
    walk_s   = shreg_r;
    walk_c_s = cout_r;
    walk_o_s = ovf_r;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(rem_r)) begin
        stp      = step_once(walk_s, drc_r, mode_r);
        walk_o_s = walk_o_s | ((mode_r == 2'b01) && !drc_r && (stp[WIDTH-1] != walk_s[WIDTH-1]));
        walk_c_s = stp[WIDTH];
        walk_s   = stp[WIDTH-1:0];
      end else begin
        walk_s   = walk_s;
      end
    end
    if (int'(rem_r) > STEP) begin
      rem_dec_s = rem_r - AMT_W'(STEP);
    end else begin
      rem_dec_s = '0;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = Start ? SHIFT : IDLE;
      SHIFT:   state_s = (rem_r == '0) ? IDLE : SHIFT;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the datapath and the registered outputs.
  always_comb begin
    shreg_s = shreg_r;
    rem_s   = rem_r;
    drc_s   = drc_r;
    mode_s  = mode_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    dout_s  = dout_r;
    cout_s  = cout_r;
    ovf_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          shreg_s = Din;
          rem_s   = Num;
          drc_s   = Drc;
          mode_s  = Mode;
          cout_s  = 1'b0;
          ovf_s   = 1'b0;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      SHIFT: begin
        if (rem_r != '0) begin
          shreg_s = walk_s;
          cout_s  = walk_c_s;
          ovf_s   = walk_o_s;
          rem_s   = rem_dec_s;
        end else begin
          dout_s  = shreg_r;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shreg_r <= '0;
      rem_r   <= '0;
      drc_r   <= 1'b0;
      mode_r  <= 2'b00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dout_r  <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      shreg_r <= shreg_s;
      rem_r   <= rem_s;
      drc_r   <= drc_s;
      mode_r  <= mode_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      dout_r  <= dout_s;
      cout_r  <= cout_s;
      ovf_r   <= ovf_s;
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign Dout = dout_r;
  assign Cout = cout_r;
  assign Ovf  = ovf_r;

endmodule
